// File: rtl/rename_multi_pkg.sv
// Shared sizing constants for the multi-wide rename stage and its free ring.
// The free-ring depth is derived from the physical and architectural register counts.
package rename_multi_pkg;

  localparam int RENAME_WIDTH = 2;
  localparam int COMMIT_WIDTH = 2;
  localparam int AREG_WIDTH   = 5;
  localparam int PREG_WIDTH   = 6;
  localparam int NUM_AREG     = 32;
  localparam int NUM_PREG     = 64;
  localparam int FL_DEPTH     = NUM_PREG - NUM_AREG;
  localparam int FL_PTR_WIDTH = $clog2(FL_DEPTH);
  localparam int FL_CNT_WIDTH = $clog2(FL_DEPTH + 1);
  localparam int POPC_WIDTH   = $clog2(RENAME_WIDTH + 1);

  // Pointer advance modulo a ring depth that need not be a power of two.
  function automatic int unsigned wrap_add(input int unsigned p, input int unsigned k,
                                           input int unsigned depth);
    int unsigned s;
    s = p + k;
    return (s >= depth) ? s - depth : s;
  endfunction

endpackage

// File: rtl/rename_free_ring.sv
// Circular free list: multi-pop at head for rename, multi-push at tail for commit.
// A flush moves head back to the post-commit tail, freeing every in-flight tag.
module rename_free_ring
  import rename_multi_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [POPC_WIDTH-1:0]              pop_cnt,
  input  logic [COMMIT_WIDTH-1:0]            push_valid,
  input  logic [COMMIT_WIDTH*PREG_WIDTH-1:0] push_tag,
  input  logic                               flush,
  output logic [RENAME_WIDTH*PREG_WIDTH-1:0] cand_tag,
  output logic [FL_CNT_WIDTH-1:0]            count
);

  logic [PREG_WIDTH-1:0]   ring [FL_DEPTH];
  logic [FL_PTR_WIDTH-1:0] head;
  logic [FL_PTR_WIDTH-1:0] tail;
  logic [FL_PTR_WIDTH-1:0] tail_next;
  logic [FL_PTR_WIDTH-1:0] push_ptr [COMMIT_WIDTH];
  logic [FL_CNT_WIDTH-1:0] push_cnt;

  always_comb begin
    int unsigned n;
    n = 0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      push_ptr[k] = FL_PTR_WIDTH'(wrap_add(32'(tail), n, FL_DEPTH));
      if (push_valid[k]) n++;
    end
    push_cnt  = FL_CNT_WIDTH'(n);
    tail_next = FL_PTR_WIDTH'(wrap_add(32'(tail), n, FL_DEPTH));
  end

  always_comb begin
    cand_tag = '0;
    for (int k = 0; k < RENAME_WIDTH; k++)
      cand_tag[k*PREG_WIDTH +: PREG_WIDTH] = ring[FL_PTR_WIDTH'(wrap_add(32'(head), k, FL_DEPTH))];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < FL_DEPTH; k++) ring[k] <= PREG_WIDTH'(NUM_AREG + k);
      head  <= '0;
      tail  <= '0;
      count <= FL_CNT_WIDTH'(FL_DEPTH);
    end else begin
      for (int k = 0; k < COMMIT_WIDTH; k++)
        if (push_valid[k]) ring[push_ptr[k]] <= push_tag[k*PREG_WIDTH +: PREG_WIDTH];
      tail <= tail_next;
      // Slots in [tail,head) still hold their allocated tags, so rewinding head frees them.
      if (flush) begin
        head  <= tail_next;
        count <= FL_CNT_WIDTH'(FL_DEPTH);
      end else begin
        head  <= FL_PTR_WIDTH'(wrap_add(32'(head), 32'(pop_cnt), FL_DEPTH));
        count <= count + push_cnt - FL_CNT_WIDTH'(pop_cnt);
      end
    end
  end

endmodule

// File: rtl/rename_multi.sv
// N-wide register rename: speculative and retirement RATs, same-group dependency
// override, free-ring allocation at rename and release at commit, flush restore.
module rename_multi
  import rename_multi_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [RENAME_WIDTH-1:0]            in_lane_vld,
  input  logic [RENAME_WIDTH-1:0]            in_reg_write,
  input  logic [RENAME_WIDTH*AREG_WIDTH-1:0] in_rd,
  input  logic [RENAME_WIDTH*AREG_WIDTH-1:0] in_rs1,
  input  logic [RENAME_WIDTH*AREG_WIDTH-1:0] in_rs2,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [RENAME_WIDTH-1:0]            out_lane_vld,
  output logic [RENAME_WIDTH*PREG_WIDTH-1:0] out_prd,
  output logic [RENAME_WIDTH*PREG_WIDTH-1:0] out_prs1,
  output logic [RENAME_WIDTH*PREG_WIDTH-1:0] out_prs2,
  output logic [RENAME_WIDTH*PREG_WIDTH-1:0] out_old_prd,
  input  logic [COMMIT_WIDTH-1:0]            commit_valid,
  input  logic [COMMIT_WIDTH*AREG_WIDTH-1:0] commit_areg,
  input  logic [COMMIT_WIDTH*PREG_WIDTH-1:0] commit_prd,
  input  logic [COMMIT_WIDTH*PREG_WIDTH-1:0] commit_old_prd,
  input  logic                               flush,
  output logic [FL_CNT_WIDTH-1:0]            free_count
);

  logic [PREG_WIDTH-1:0] spec_rat [NUM_AREG];
  logic [PREG_WIDTH-1:0] ret_rat  [NUM_AREG];
  logic [PREG_WIDTH-1:0] ret_next [NUM_AREG];

  logic [AREG_WIDTH-1:0] rd  [RENAME_WIDTH];
  logic [AREG_WIDTH-1:0] rs1 [RENAME_WIDTH];
  logic [AREG_WIDTH-1:0] rs2 [RENAME_WIDTH];
  logic [RENAME_WIDTH-1:0] alloc;

  logic [PREG_WIDTH-1:0] new_tag [RENAME_WIDTH];
  logic [PREG_WIDTH-1:0] prs1_c  [RENAME_WIDTH];
  logic [PREG_WIDTH-1:0] prs2_c  [RENAME_WIDTH];
  logic [PREG_WIDTH-1:0] old_c   [RENAME_WIDTH];

  logic [RENAME_WIDTH*PREG_WIDTH-1:0] cand_tag;
  logic [POPC_WIDTH-1:0] alloc_cnt;
  logic [POPC_WIDTH-1:0] pop_cnt;
  logic fire;

  for (genvar i = 0; i < RENAME_WIDTH; i++) begin : g_lane
    assign rd[i]    = in_rd[i*AREG_WIDTH +: AREG_WIDTH];
    assign rs1[i]   = in_rs1[i*AREG_WIDTH +: AREG_WIDTH];
    assign rs2[i]   = in_rs2[i*AREG_WIDTH +: AREG_WIDTH];
    assign alloc[i] = in_lane_vld[i] & in_reg_write[i] & (rd[i] != '0);
  end

  // Deliberately conservative: demands a full group's worth of tags regardless of alloc count.
  assign in_ready = !flush && (free_count >= FL_CNT_WIDTH'(RENAME_WIDTH)) && (!out_valid || out_ready);
  assign fire     = in_valid && in_ready;
  assign pop_cnt  = fire ? alloc_cnt : '0;

  always_comb begin
    int unsigned n;
    n = 0;
    for (int j = 0; j < RENAME_WIDTH; j++) begin
      new_tag[j] = '0;
      if (alloc[j]) begin
        new_tag[j] = cand_tag[n*PREG_WIDTH +: PREG_WIDTH];
        n++;
      end
    end
    alloc_cnt = POPC_WIDTH'(n);
  end

  // Older lanes in the group shadow the RAT; the loop order makes the newest writer win.
  always_comb begin
    for (int j = 0; j < RENAME_WIDTH; j++) begin
      prs1_c[j] = spec_rat[rs1[j]];
      prs2_c[j] = spec_rat[rs2[j]];
      old_c[j]  = spec_rat[rd[j]];
      for (int i = 0; i < j; i++) begin
        if (alloc[i] && rd[i] == rs1[j]) prs1_c[j] = new_tag[i];
        if (alloc[i] && rd[i] == rs2[j]) prs2_c[j] = new_tag[i];
        if (alloc[i] && rd[i] == rd[j])  old_c[j]  = new_tag[i];
      end
      if (rs1[j] == '0) prs1_c[j] = '0;
      if (rs2[j] == '0) prs2_c[j] = '0;
      if (!alloc[j])    old_c[j]  = '0;
    end
  end

  always_comb begin
    ret_next = ret_rat;
    for (int k = 0; k < COMMIT_WIDTH; k++)
      if (commit_valid[k] && commit_areg[k*AREG_WIDTH +: AREG_WIDTH] != '0)
        ret_next[commit_areg[k*AREG_WIDTH +: AREG_WIDTH]] = commit_prd[k*PREG_WIDTH +: PREG_WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_AREG; i++) ret_rat[i] <= PREG_WIDTH'(i);
    end else begin
      ret_rat <= ret_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_AREG; i++) spec_rat[i] <= PREG_WIDTH'(i);
    end else if (flush) begin
      spec_rat <= ret_next;
    end else if (fire) begin
      for (int j = 0; j < RENAME_WIDTH; j++)
        if (alloc[j]) spec_rat[rd[j]] <= new_tag[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_lane_vld <= '0;
      out_prd      <= '0;
      out_prs1     <= '0;
      out_prs2     <= '0;
      out_old_prd  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid    <= 1'b1;
      out_lane_vld <= in_lane_vld;
      for (int j = 0; j < RENAME_WIDTH; j++) begin
        out_prd[j*PREG_WIDTH +: PREG_WIDTH]     <= new_tag[j];
        out_prs1[j*PREG_WIDTH +: PREG_WIDTH]    <= prs1_c[j];
        out_prs2[j*PREG_WIDTH +: PREG_WIDTH]    <= prs2_c[j];
        out_old_prd[j*PREG_WIDTH +: PREG_WIDTH] <= old_c[j];
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  rename_free_ring u_free_ring (
    .clk        (clk),
    .rst_n      (rst_n),
    .pop_cnt    (pop_cnt),
    .push_valid (commit_valid),
    .push_tag   (commit_old_prd),
    .flush      (flush),
    .cand_tag   (cand_tag),
    .count      (free_count)
  );

endmodule

// File: tb/tb_rename_multi.sv
// Directed bench for rename_multi: table of single-group renames plus sequences for
// exhaustion/wrap, backpressure, flush with same-cycle commit and mid-run reset.
module tb_rename_multi;
  import rename_multi_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready;
  logic [RENAME_WIDTH-1:0] in_lane_vld, in_reg_write;
  logic [RENAME_WIDTH*AREG_WIDTH-1:0] in_rd, in_rs1, in_rs2;
  logic out_valid, out_ready;
  logic [RENAME_WIDTH-1:0] out_lane_vld;
  logic [RENAME_WIDTH*PREG_WIDTH-1:0] out_prd, out_prs1, out_prs2, out_old_prd;
  logic [COMMIT_WIDTH-1:0] commit_valid;
  logic [COMMIT_WIDTH*AREG_WIDTH-1:0] commit_areg;
  logic [COMMIT_WIDTH*PREG_WIDTH-1:0] commit_prd, commit_old_prd;
  logic flush;
  logic [FL_CNT_WIDTH-1:0] free_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int vld, rw, rd0, rs10, rs20, rd1, rs11, rs21;
    int prd0, prd1, p10, p11, p20, p21, old0, old1, fc;
  } vec_t;
  vec_t tab [6];

  rename_multi dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_vld(in_lane_vld), .in_reg_write(in_reg_write),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane_vld(out_lane_vld),
    .out_prd(out_prd), .out_prs1(out_prs1), .out_prs2(out_prs2), .out_old_prd(out_old_prd),
    .commit_valid(commit_valid), .commit_areg(commit_areg),
    .commit_prd(commit_prd), .commit_old_prd(commit_old_prd),
    .flush(flush), .free_count(free_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int ln(input logic [RENAME_WIDTH*PREG_WIDTH-1:0] v, input int k);
    return int'(v[k*PREG_WIDTH +: PREG_WIDTH]);
  endfunction

  task automatic set_in(input int vld, input int rw, input int rd0, input int rs10, input int rs20,
                        input int rd1, input int rs11, input int rs21);
    in_lane_vld  = 2'(vld);
    in_reg_write = 2'(rw);
    in_rd        = {5'(rd1), 5'(rd0)};
    in_rs1       = {5'(rs11), 5'(rs10)};
    in_rs2       = {5'(rs21), 5'(rs20)};
  endtask

  task automatic commit1(input int areg, input int prd, input int old);
    commit_valid   = 2'b01;
    commit_areg    = {5'd0, 5'(areg)};
    commit_prd     = {6'd0, 6'(prd)};
    commit_old_prd = {6'd0, 6'(old)};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Commit protocol monitor: lanes contiguous from 0, never commit into a full ring.
  always @(negedge clk) begin
    if (rst_n && commit_valid != '0) begin
      chk("commit_contiguous", int'(commit_valid == 2'b10), 0);
      chk("commit_ring_not_full", int'(free_count == FL_CNT_WIDTH'(FL_DEPTH)), 0);
    end
  end

  initial begin
    tab[0] = '{3, 3, 1, 2, 3, 4, 5, 0, 32, 33, 2, 5, 3, 0, 1, 4, 30};
    tab[1] = '{3, 3, 5, 1, 4, 5, 5, 1, 34, 35, 32, 34, 33, 32, 5, 34, 28};
    tab[2] = '{3, 1, 0, 5, 4, 6, 0, 1, 0, 0, 35, 0, 33, 32, 0, 0, 28};
    tab[3] = '{1, 3, 7, 5, 6, 8, 0, 0, 36, 0, 35, 0, 6, 0, 7, 0, 27};
    tab[4] = '{3, 3, 3, 3, 7, 9, 3, 9, 37, 38, 3, 37, 36, 9, 3, 9, 25};
    tab[5] = '{3, 2, 9, 9, 3, 3, 3, 9, 0, 39, 38, 37, 37, 38, 0, 37, 24};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    commit_valid = '0; commit_areg = '0; commit_prd = '0; commit_old_prd = '0;
    tick(); tick();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_free_count", int'(free_count), 32);
    chk("rst_out_prd", int'(out_prd), 0);
    chk("rst_out_old_prd", int'(out_old_prd), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      set_in(tab[i].vld, tab[i].rw, tab[i].rd0, tab[i].rs10, tab[i].rs20,
             tab[i].rd1, tab[i].rs11, tab[i].rs21);
      in_valid = 1'b1;
      #1;
      chk($sformatf("v%0d_in_ready", i), int'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      chk($sformatf("v%0d_out_valid", i), int'(out_valid), 1);
      chk($sformatf("v%0d_lane_vld", i), int'(out_lane_vld), tab[i].vld);
      chk($sformatf("v%0d_prd0", i), ln(out_prd, 0), tab[i].prd0);
      chk($sformatf("v%0d_prd1", i), ln(out_prd, 1), tab[i].prd1);
      chk($sformatf("v%0d_prs1_0", i), ln(out_prs1, 0), tab[i].p10);
      chk($sformatf("v%0d_prs1_1", i), ln(out_prs1, 1), tab[i].p11);
      chk($sformatf("v%0d_prs2_0", i), ln(out_prs2, 0), tab[i].p20);
      chk($sformatf("v%0d_prs2_1", i), ln(out_prs2, 1), tab[i].p21);
      chk($sformatf("v%0d_old0", i), ln(out_old_prd, 0), tab[i].old0);
      chk($sformatf("v%0d_old1", i), ln(out_old_prd, 1), tab[i].old1);
      chk($sformatf("v%0d_free_count", i), int'(free_count), tab[i].fc);
    end

    // Asynchronous reset while a group is held in the output register.
    rst_n = 1'b0;
    #2;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_free_count", int'(free_count), 32);
    chk("midrst_out_prd", int'(out_prd), 0);
    tick();
    rst_n = 1'b1;

    // Exhaustion, partial release and wrap-around.
    set_in(3, 3, 1, 0, 0, 2, 0, 0);
    in_valid = 1'b1;
    for (int g = 0; g < 16; g++) begin
      #1;
      chk($sformatf("exh_in_ready_g%0d", g), int'(in_ready), 1);
      tick();
    end
    in_valid = 1'b0;
    chk("exh_last_prd0", ln(out_prd, 0), 62);
    chk("exh_last_prd1", ln(out_prd, 1), 63);
    chk("exh_free_count", int'(free_count), 0);
    chk("exh_in_ready", int'(in_ready), 0);
    commit1(1, 32, 1);
    tick();
    commit_valid = '0;
    chk("exh_c1_free_count", int'(free_count), 1);
    chk("exh_c1_in_ready", int'(in_ready), 0);
    commit1(2, 33, 2);
    tick();
    commit_valid = '0;
    chk("exh_c2_free_count", int'(free_count), 2);
    chk("exh_c2_in_ready", int'(in_ready), 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("wrap_prd0", ln(out_prd, 0), 1);
    chk("wrap_prd1", ln(out_prd, 1), 2);
    chk("wrap_old0", ln(out_old_prd, 0), 62);
    chk("wrap_old1", ln(out_old_prd, 1), 63);
    chk("wrap_free_count", int'(free_count), 0);

    // Backpressure: output register holds, nothing pops, then consume-and-fire.
    do_reset();
    out_ready = 1'b0;
    set_in(3, 3, 1, 0, 0, 2, 0, 0);
    in_valid = 1'b1;
    tick();
    chk("bp_a_valid", int'(out_valid), 1);
    chk("bp_a_prd0", ln(out_prd, 0), 32);
    set_in(3, 3, 3, 1, 2, 4, 3, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp_in_ready_c%0d", c), int'(in_ready), 0);
      tick();
      chk($sformatf("bp_valid_c%0d", c), int'(out_valid), 1);
      chk($sformatf("bp_prd0_c%0d", c), ln(out_prd, 0), 32);
      chk($sformatf("bp_prd1_c%0d", c), ln(out_prd, 1), 33);
      chk($sformatf("bp_free_count_c%0d", c), int'(free_count), 30);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("bp_b_valid", int'(out_valid), 1);
    chk("bp_b_prd0", ln(out_prd, 0), 34);
    chk("bp_b_prd1", ln(out_prd, 1), 35);
    chk("bp_b_prs1_0", ln(out_prs1, 0), 32);
    chk("bp_b_prs1_1", ln(out_prs1, 1), 34);
    chk("bp_b_prs2_0", ln(out_prs2, 0), 33);
    chk("bp_b_free_count", int'(free_count), 28);
    tick();
    chk("bp_drained_valid", int'(out_valid), 0);

    // Flush with a same-cycle commit of the oldest allocation.
    do_reset();
    in_valid = 1'b1;
    for (int g = 0; g < 4; g++) begin
      set_in(3, 3, 2*g + 1, 0, 0, 2*g + 2, 0, 0);
      tick();
    end
    chk("fl_pre_free_count", int'(free_count), 24);
    set_in(3, 3, 9, 1, 3, 10, 2, 1);
    flush = 1'b1;
    commit1(1, 32, 1);
    #1;
    chk("fl_in_ready", int'(in_ready), 0);
    tick();
    flush = 1'b0;
    commit_valid = '0;
    chk("fl_out_valid", int'(out_valid), 0);
    chk("fl_free_count", int'(free_count), 32);
    #1;
    chk("fl_post_in_ready", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("fl_prd0", ln(out_prd, 0), 33);
    chk("fl_prd1", ln(out_prd, 1), 34);
    chk("fl_prs1_0", ln(out_prs1, 0), 32);
    chk("fl_prs1_1", ln(out_prs1, 1), 2);
    chk("fl_prs2_0", ln(out_prs2, 0), 3);
    chk("fl_prs2_1", ln(out_prs2, 1), 32);
    chk("fl_old0", ln(out_old_prd, 0), 9);
    chk("fl_old1", ln(out_old_prd, 1), 10);
    chk("fl_next_free_count", int'(free_count), 30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
